mask_dec: RTL and testbench
===========================

Name: mask_dec

Overview:
- Inverse of the unary mask generator: accepts a unary/thermometer mask vector and recovers the one-hot selection bit that produced it, plus its binary index.
- Used wherever a stored or transported mask must be turned back into a pointer, e.g. round-robin arbiter state, ROB/LSQ head-tail masks, and flush-boundary masks.
- Streaming block with valid/ready on both sides and a single registered output stage, sustaining full throughput.

Parameters:
- W, 8, vector width (W >= 2).
- TOWARDS_LSB, 1, mask fill direction; must match the generating mask.
- INCLUSIVE, 0, mask includes the selection bit; must match the generating mask.
- CNT_W, 8, width of the error counter (used only with the check feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_in_vld  in  1  input mask valid
- i_in_y  in  W  input mask
- o_in_rdy  out  1  block can accept an input this cycle
- o_out_vld  out  1  decoded result valid
- o_out_x  out  W  recovered one-hot vector
- o_out_idx  out  $clog2(W)  binary index of o_out_x
- o_out_zero  out  1  input encoded "no selection" (inclusive mode only)
- i_out_rdy  in  1  downstream accepts the result
- o_out_err  out  1  input was not a legal mask (feature only)
- o_err_cnt  out  CNT_W  saturating count of illegal masks (feature only)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: o_out_vld=0, o_out_x=0, o_out_idx=0, o_out_zero=0, o_out_err=0, o_err_cnt=0.
- Mask definition, for selection bit k:
  - TOWARDS_LSB=1: y[j]=1 for j<k, or j<=k if INCLUSIVE.
  - TOWARDS_LSB=0: y[j]=1 for j>k, or j>=k if INCLUSIVE.
- Decode:
  - TOWARDS_LSB=1, INCLUSIVE=1: x = y & ~(y>>1).
  - TOWARDS_LSB=1, INCLUSIVE=0: x = (y<<1) & ~y, truncated to W bits.
  - TOWARDS_LSB=0: mirror images of the above.
- All-zero y:
  - Inclusive mode: x=0, idx=0, o_out_zero=1.
  - Exclusive mode: x is the edge bit (bit 0 for TOWARDS_LSB=1, bit W-1 otherwise), o_out_zero=0.
- o_out_idx is the priority-encoded position of x; it is 0 when x=0.
- Pipeline: a single register slice.
  - o_in_rdy = !o_out_vld || i_out_rdy (combinational).
  - Transfer on i_in_vld && o_in_rdy; the result appears on o_out_vld the next cycle, so latency is 1.
- Output holding: while o_out_vld && !i_out_rdy, every o_out_* output holds stable.
- Throughput: back-to-back inputs with i_out_rdy held high give one result per cycle.
- Simultaneous pop and push: the register is overwritten with the new result and o_out_vld stays 1.
- Pop with no push: o_out_vld falls to 0. Data outputs may retain their old values and are don't-care while o_out_vld=0.
- Reset mid-operation: any held result is discarded and all outputs return to their reset values on the next edge. o_in_rdy=1 during and after reset.

Optional Feature:
- Macro: MASK_DEC_CHECK_EN.
- When defined, a legality check is applied to every accepted input:
  - TOWARDS_LSB=1: y is legal iff (y & (y+1)) == 0.
  - TOWARDS_LSB=0: the same test is applied to ~y.
  - In exclusive mode, all-ones y is additionally illegal (it implies k outside 0..W-1).
- For an illegal input:
  - o_out_err=1 alongside the result.
  - o_out_x / o_out_idx still carry the raw decode formula result.
  - o_err_cnt increments on acceptance and saturates at 2^CNT_W-1.
- When undefined: o_out_err and o_err_cnt are tied to 0, and no check logic or counter registers exist.

Decomposition:
- Shared package mask_pkg holds:
  - mask_dir_t enum (LSB, MSB).
  - A clog2-based idx width helper, MASK_IDX_W(W).
  - The decode result struct: x, idx, zero, err.
- Natural sub-module: pri_enc (one-hot to binary index), reusable by arbiters.
- The combinational decode stays inside mask_dec.

Test Plan:
- W=8, LSB, exclusive: y=8'b0000_0111 -> next cycle o_out_vld=1, x=8'b0000_1000, idx=3.
- W=8, LSB, inclusive: y=8'b0000_0111 -> x=8'b0000_0100, idx=2. y=0 -> x=0, o_out_zero=1.
- W=8, MSB, exclusive: y=8'b1110_0000 -> x=8'b0001_0000, idx=4. y=0 -> x=8'b1000_0000, idx=7.
- Backpressure: push 3 masks with i_out_rdy=0 for 4 cycles -> first result held stable, o_in_rdy=0, no loss. Release -> results delivered in order, one per cycle.
- With MASK_DEC_CHECK_EN, LSB exclusive, CNT_W=2:
  - y=8'b0000_0101 -> o_out_err=1, o_err_cnt=1.
  - y=8'hFF -> o_out_err=1.
  - Five illegal inputs in total -> o_err_cnt saturates at 3.
- Reset asserted while o_out_vld=1 and i_out_rdy=0 -> next cycle o_out_vld=0, o_err_cnt=0, o_in_rdy=1.

Source files
------------

// File: rtl/mask_pkg.sv
// Shared types and helpers for unary/thermometer mask handling.
// The result struct is sized for the widest supported vector; users slice out the low W bits.
package mask_pkg;

  typedef enum logic {
    LSB = 1'b0,
    MSB = 1'b1
  } mask_dir_t;

  localparam int MASK_MAX_W     = 64;
  localparam int MASK_MAX_IDX_W = 6;

  function automatic int MASK_IDX_W(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  typedef struct packed {
    logic [MASK_MAX_W-1:0]     x;
    logic [MASK_MAX_IDX_W-1:0] idx;
    logic                      zero;
    logic                      err;
  } mask_res_t;

endpackage

// File: rtl/pri_enc.sv
// One-hot to binary index encoder; the lowest set bit wins, and an all-zero input gives 0.
module pri_enc
  import mask_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = MASK_IDX_W(W)
) (
  input  logic [W-1:0]  x,
  output logic [IW-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/mask_dec.sv
// Thermometer mask -> one-hot + index decoder with a single valid/ready register slice.
// Optional legality check and saturating error counter under `MASK_DEC_CHECK_EN.
module mask_dec
  import mask_pkg::*;
#(
  parameter int W           = 8,
  parameter bit TOWARDS_LSB = 1'b1,
  parameter bit INCLUSIVE   = 1'b0,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_in_vld,
  input  logic [W-1:0]             i_in_y,
  output logic                     o_in_rdy,
  output logic                     o_out_vld,
  output logic [W-1:0]             o_out_x,
  output logic [MASK_IDX_W(W)-1:0] o_out_idx,
  output logic                     o_out_zero,
  input  logic                     i_out_rdy,
  output logic                     o_out_err,
  output logic [CNT_W-1:0]         o_err_cnt
);

  localparam int        IW  = MASK_IDX_W(W);
  localparam mask_dir_t DIR = TOWARDS_LSB ? LSB : MSB;

  logic [W-1:0]  x_dec;
  logic [IW-1:0] idx_dec;
  logic          zero_dec;
  logic          err_dec;
  logic          accept;
  logic          vld_q;
  mask_res_t     res_d;
  mask_res_t     res_q;

  assign o_in_rdy = !vld_q || i_out_rdy;
  assign accept   = i_in_vld && o_in_rdy;

  // An empty exclusive mask means the selection sits on the edge the mask grows from.
  always_comb begin
    x_dec = '0;
    if (DIR == LSB) begin
      if (INCLUSIVE)           x_dec = i_in_y & ~(i_in_y >> 1);
      else if (i_in_y == '0)   x_dec = W'(1);
      else                     x_dec = (i_in_y << 1) & ~i_in_y;
    end else begin
      if (INCLUSIVE)           x_dec = i_in_y & ~(i_in_y << 1);
      else if (i_in_y == '0)   x_dec = {1'b1, {(W-1){1'b0}}};
      else                     x_dec = (i_in_y >> 1) & ~i_in_y;
    end
  end

  assign zero_dec = INCLUSIVE && (i_in_y == '0);

  pri_enc #(
    .W  (W),
    .IW (IW)
  ) u_pri_enc (
    .x   (x_dec),
    .idx (idx_dec)
  );

`ifdef MASK_DEC_CHECK_EN
  logic [W-1:0]     y_norm;
  logic [W-1:0]     y_inc;
  logic [CNT_W-1:0] err_cnt_q;

  // A legal mask, normalised to fill from bit 0, is a run of low ones: adding 1 clears every set bit.
  always_comb begin
    y_norm  = (DIR == LSB) ? i_in_y : ~i_in_y;
    y_inc   = y_norm + W'(1);
    err_dec = (y_norm & y_inc) != '0;
    if (!INCLUSIVE && (i_in_y == '1)) err_dec = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (accept && err_dec && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign o_out_err = res_q.err;
  assign o_err_cnt = err_cnt_q;
`else
  assign err_dec   = 1'b0;
  assign o_out_err = 1'b0;
  assign o_err_cnt = '0;
`endif

  always_comb begin
    res_d           = '0;
    res_d.x[W-1:0]  = x_dec;
    res_d.idx[IW-1:0] = idx_dec;
    res_d.zero      = zero_dec;
    res_d.err       = err_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      vld_q <= 1'b1;
      res_q <= res_d;
    end else if (i_out_rdy) begin
      vld_q <= 1'b0;
    end
  end

  assign o_out_vld  = vld_q;
  assign o_out_x    = res_q.x[W-1:0];
  assign o_out_idx  = res_q.idx[IW-1:0];
  assign o_out_zero = res_q.zero;

  // Struct bits above W/IW are always zero and never reach a port.
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int i = W; i < MASK_MAX_W; i++)     unused_bits ^= res_q.x[i];
    for (int i = IW; i < MASK_MAX_IDX_W; i++) unused_bits ^= res_q.idx[i];
`ifndef MASK_DEC_CHECK_EN
    unused_bits ^= res_q.err;
`endif
  end

endmodule

// File: tb/tb_mask_dec.sv
// Bench for mask_dec: four W=8 instances (LSB/MSB x exclusive/inclusive) share one input stream.
module tb_mask_dec;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam logic [N-1:0] CFG_LSB = 4'b0011;
  localparam logic [N-1:0] CFG_INC = 4'b1010;
`ifdef MASK_DEC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [7:0] in_y;
  logic       out_rdy;

  logic       in_rdy   [N];
  logic       out_vld  [N];
  logic [7:0] out_x    [N];
  logic [2:0] out_idx  [N];
  logic       out_zero [N];
  logic       out_err  [N];
  logic [1:0] err_cnt  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mask_dec #(
      .W           (W),
      .TOWARDS_LSB (CFG_LSB[g]),
      .INCLUSIVE   (CFG_INC[g]),
      .CNT_W       (CW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_in_vld   (in_vld),
      .i_in_y     (in_y),
      .o_in_rdy   (in_rdy[g]),
      .o_out_vld  (out_vld[g]),
      .o_out_x    (out_x[g]),
      .o_out_idx  (out_idx[g]),
      .o_out_zero (out_zero[g]),
      .i_out_rdy  (out_rdy),
      .o_out_err  (out_err[g]),
      .o_err_cnt  (err_cnt[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mask produced by the generator for selection bit k.
  function automatic logic [7:0] mask_of(input bit lsb, input bit inc, input int k);
    logic [7:0] m;
    for (int j = 0; j < 8; j++) begin
      if (lsb) m[j] = inc ? (j <= k) : (j < k);
      else     m[j] = inc ? (j >= k) : (j > k);
    end
    return m;
  endfunction

  // Legal masks are recognised by matching against every generator output; anything else
  // falls back to the raw bitwise decode formula.
  function automatic void decode(input bit lsb, input bit inc, input logic [7:0] y,
                                 output logic [7:0] x, output logic [2:0] idx,
                                 output bit zero, output bit legal);
    logic [9:0] ye;
    x = '0; idx = '0; zero = 1'b0; legal = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!legal && mask_of(lsb, inc, k) == y) begin
        x[k] = 1'b1;
        legal = 1'b1;
      end
    end
    if (!legal && inc && y == 8'h00) begin
      zero = 1'b1;
      legal = 1'b1;
    end
    if (!legal) begin
      ye = {1'b0, y, 1'b0};
      for (int j = 0; j < 8; j++) begin
        if (lsb && inc)       x[j] = y[j] & ~ye[j+2];
        else if (lsb)         x[j] = ye[j] & ~y[j];
        else if (inc)         x[j] = y[j] & ~ye[j];
        else                  x[j] = ye[j+2] & ~y[j];
      end
    end
    for (int j = 7; j >= 0; j--) if (x[j]) idx = 3'(j);
  endfunction

  // Reference pipeline: one holding slot, counters per instance.
  bit         m_vld = 1'b0;
  logic [7:0] m_y   = '0;
  bit         m_acc = 1'b0;
  int         m_cnt [N];
  bit         chk_on = 1'b0;

  always @(posedge clk) begin
    logic [7:0] mx; logic [2:0] mi; bit mz, ml;
    m_acc = !rst && in_vld && (!m_vld || out_rdy);
    if (rst) begin
      m_vld = 1'b0;
      for (int g = 0; g < N; g++) m_cnt[g] = 0;
    end else if (m_acc) begin
      m_vld = 1'b1;
      m_y   = in_y;
      for (int g = 0; g < N; g++) begin
        decode(CFG_LSB[g], CFG_INC[g], in_y, mx, mi, mz, ml);
        if (CHK && !ml && m_cnt[g] < 3) m_cnt[g]++;
      end
    end else if (out_rdy) begin
      m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    logic [7:0] ex; logic [2:0] ei; bit ez, el;
    if (chk_on) begin
      for (int g = 0; g < N; g++) begin
        check($sformatf("in_rdy[%0d]", g), 32'(in_rdy[g]), 32'(!m_vld || out_rdy));
        check($sformatf("out_vld[%0d]", g), 32'(out_vld[g]), 32'(m_vld));
        check($sformatf("err_cnt[%0d]", g), 32'(err_cnt[g]), 32'(m_cnt[g]));
        if (m_vld) begin
          decode(CFG_LSB[g], CFG_INC[g], m_y, ex, ei, ez, el);
          check($sformatf("x[%0d] y=%0h", g, m_y), 32'(out_x[g]), 32'(ex));
          check($sformatf("idx[%0d] y=%0h", g, m_y), 32'(out_idx[g]), 32'(ei));
          check($sformatf("zero[%0d] y=%0h", g, m_y), 32'(out_zero[g]), 32'(ez));
          check($sformatf("err[%0d] y=%0h", g, m_y), 32'(out_err[g]), 32'(CHK && !el));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push(input logic [7:0] y, output int cyc);
    bit done;
    done = 1'b0;
    cyc = 0;
    in_vld = 1'b1;
    in_y = y;
    while (!done && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_acc) done = 1'b1;
    end
    in_vld = 1'b0;
    check($sformatf("push_accept y=%0h", y), 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] px; logic [2:0] pi; bit pz, pl;
    int c;
    rst = 1'b1; in_vld = 1'b0; in_y = '0; out_rdy = 1'b1;

    // Pin the reference decode against hand-worked cases.
    decode(1'b1, 1'b0, 8'h07, px, pi, pz, pl);
    check("model lsb_exc 07 x", 32'(px), 32'h08);
    check("model lsb_exc 07 idx", 32'(pi), 32'd3);
    decode(1'b1, 1'b1, 8'h00, px, pi, pz, pl);
    check("model lsb_inc 00 zero", 32'(pz), 32'd1);
    decode(1'b0, 1'b0, 8'h00, px, pi, pz, pl);
    check("model msb_exc 00 x", 32'(px), 32'h80);
    decode(1'b1, 1'b0, 8'h05, px, pi, pz, pl);
    check("model lsb_exc 05 legal", 32'(pl), 32'd0);

    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst vld[%0d]", g), 32'(out_vld[g]), 32'd0);
      check($sformatf("rst x[%0d]", g), 32'(out_x[g]), 32'd0);
      check($sformatf("rst idx[%0d]", g), 32'(out_idx[g]), 32'd0);
      check($sformatf("rst zero[%0d]", g), 32'(out_zero[g]), 32'd0);
      check($sformatf("rst err[%0d]", g), 32'(out_err[g]), 32'd0);
      check($sformatf("rst in_rdy[%0d]", g), 32'(in_rdy[g]), 32'd1);
    end

    step();
    push(8'h07, c);
    @(negedge clk);
    check("lsb_exc 07 vld", 32'(out_vld[0]), 32'd1);
    check("lsb_exc 07 x", 32'(out_x[0]), 32'h08);
    check("lsb_exc 07 idx", 32'(out_idx[0]), 32'd3);
    check("lsb_inc 07 x", 32'(out_x[1]), 32'h04);
    check("lsb_inc 07 idx", 32'(out_idx[1]), 32'd2);

    step();
    push(8'h00, c);
    @(negedge clk);
    check("lsb_inc 00 x", 32'(out_x[1]), 32'h00);
    check("lsb_inc 00 zero", 32'(out_zero[1]), 32'd1);
    check("msb_exc 00 x", 32'(out_x[2]), 32'h80);
    check("msb_exc 00 idx", 32'(out_idx[2]), 32'd7);

    step();
    push(8'hE0, c);
    @(negedge clk);
    check("msb_exc e0 x", 32'(out_x[2]), 32'h10);
    check("msb_exc e0 idx", 32'(out_idx[2]), 32'd4);

    // Backpressure: first result must hold while downstream stalls.
    step();
    out_rdy = 1'b0;
    push(8'h03, c);
    in_vld = 1'b1;
    in_y = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp hold vld", 32'(out_vld[0]), 32'd1);
      check("bp hold x", 32'(out_x[0]), 32'h04);
      check("bp in_rdy", 32'(in_rdy[0]), 32'd0);
    end
    step();
    out_rdy = 1'b1;
    push(8'h0F, c);
    push(8'h3F, c);
    check("bp back_to_back cycles", 32'(c), 32'd1);
    @(negedge clk);
    check("bp last x", 32'(out_x[0]), 32'h40);
    check("bp last idx", 32'(out_idx[0]), 32'd6);

    // Reset while a result is stalled.
    step();
    out_rdy = 1'b0;
    push(8'h01, c);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst vld", 32'(out_vld[0]), 32'd0);
    check("mid_rst cnt", 32'(err_cnt[0]), 32'd0);
    check("mid_rst in_rdy", 32'(in_rdy[0]), 32'd1);

    // Illegal masks for the LSB exclusive instance.
    step();
    out_rdy = 1'b1;
    push(8'h05, c);
    @(negedge clk);
    check("chk 05 err", 32'(out_err[0]), 32'(CHK));
    check("chk 05 cnt", 32'(err_cnt[0]), CHK ? 32'd1 : 32'd0);
    step();
    push(8'hFF, c);
    @(negedge clk);
    check("chk ff err", 32'(out_err[0]), 32'(CHK));
    step();
    push(8'h09, c);
    push(8'h0B, c);
    push(8'hF0, c);
    @(negedge clk);
    check("chk sat cnt", 32'(err_cnt[0]), CHK ? 32'd3 : 32'd0);

    // Random traffic with legal-biased masks and random downstream stalls.
    step();
    for (int i = 0; i < 600; i++) begin
      rst = (i == 300);
      in_vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        in_y = mask_of(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      else
        in_y = 8'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
